// File: rtl/char_term_pkg.sv
// Shared ASCII codes and writer state encoding for the character terminal write path.
package char_term_pkg;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_SCREEN
  } term_state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/char_clear_sweep.sv
// Cell sweep counter for line/screen clears: walks columns (and rows in screen
// mode) one cell per cycle; done is high while the final cell is presented.
module char_clear_sweep
  import char_term_pkg::*;
#(
  parameter int CHAR_HORZ_CNT = 80,
  parameter int CHAR_VERT_CNT = 30,
  parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
  parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   screen_mode,
  input  logic [CHAR_VERT_W-1:0] row_init,
  output logic                   active,
  output logic [CHAR_HORZ_W-1:0] col,
  output logic [CHAR_VERT_W-1:0] row,
  output logic                   done
);

  localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
  localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);

  logic screen;
  logic at_end;

  assign at_end = (col == H_LAST) && (!screen || (row == V_LAST));
  assign done   = active && at_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      screen <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else if (start) begin
      active <= 1'b1;
      screen <= screen_mode;
      col    <= '0;
      row    <= screen_mode ? '0 : row_init;
    end else if (active) begin
      if (col == H_LAST) begin
        col <= '0;
        if (at_end) active <= 1'b0;
        else        row    <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/char_terminal_writer.sv
// Byte-stream to character-cell writer: cursor tracking, control codes, and
// line/screen clears driven through char_clear_sweep.
module char_terminal_writer
  import char_term_pkg::*;
#(
  parameter int CHAR_HORZ_CNT = 80,
  parameter int CHAR_VERT_CNT = 30,
  parameter int CHAR_HORZ_W   = $clog2(CHAR_HORZ_CNT),
  parameter int CHAR_VERT_W   = $clog2(CHAR_VERT_CNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic [CHAR_HORZ_W-1:0] char_hpos,
  output logic [CHAR_VERT_W-1:0] char_vpos,
  output logic                   char_write_en,
  output logic [7:0]             char_symbol,
  output logic                   cursor_en,
  output logic [CHAR_HORZ_W-1:0] cursor_hpos,
  output logic [CHAR_VERT_W-1:0] cursor_vpos,
  output logic                   busy
);

  localparam logic [CHAR_HORZ_W-1:0] H_LAST = CHAR_HORZ_W'(CHAR_HORZ_CNT - 1);
  localparam logic [CHAR_VERT_W-1:0] V_LAST = CHAR_VERT_W'(CHAR_VERT_CNT - 1);

  term_state_t            state;
  logic [CHAR_HORZ_W-1:0] col;
  logic [CHAR_VERT_W-1:0] row;
  logic                   vld_p1;
  logic [CHAR_HORZ_W-1:0] hpos_p1;
  logic [CHAR_VERT_W-1:0] vpos_p1;
  logic [7:0]             sym_p1;

  logic                   acc, printable, col_wrap, row_adv;
  logic                   start_line, start_screen;
  logic [CHAR_VERT_W-1:0] row_nxt;

  logic                   sw_active, sw_done;
  logic [CHAR_HORZ_W-1:0] sw_col;
  logic [CHAR_VERT_W-1:0] sw_row;

  always_comb begin
    acc          = in_valid && in_ready && (state == ST_IDLE);
    printable    = is_printable(in_data);
    col_wrap     = printable && (col == H_LAST);
    row_adv      = acc && (col_wrap || (in_data == ASCII_LF));
    row_nxt      = row;
    if (row_adv) row_nxt = (row == V_LAST) ? '0 : row + 1'b1;
    // Only a wrap back to the top row needs that row cleared before reuse.
    start_line   = row_adv && (row == V_LAST);
    start_screen = acc && (in_data == ASCII_FF);
  end

  char_clear_sweep #(
    .CHAR_HORZ_CNT(CHAR_HORZ_CNT),
    .CHAR_VERT_CNT(CHAR_VERT_CNT),
    .CHAR_HORZ_W  (CHAR_HORZ_W),
    .CHAR_VERT_W  (CHAR_VERT_W)
  ) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .start      (start_line || start_screen),
    .screen_mode(start_screen),
    .row_init   (row_nxt),
    .active     (sw_active),
    .col        (sw_col),
    .row        (sw_row),
    .done       (sw_done)
  );

  // Stage p0 -> p1: accepted byte decoded into cursor update and write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      in_ready <= 1'b0;
      vld_p1   <= 1'b0;
      hpos_p1  <= '0;
      vpos_p1  <= '0;
      sym_p1   <= ASCII_SPACE;
    end else begin
      vld_p1 <= 1'b0;
      row    <= row_nxt;
      case (state)
        ST_IDLE: begin
          in_ready <= !(start_line || start_screen);
          if (start_line) state <= ST_CLR_LINE;
          if (acc) begin
            if (printable) begin
              vld_p1  <= 1'b1;
              hpos_p1 <= col;
              vpos_p1 <= row;
              sym_p1  <= in_data;
              col     <= col_wrap ? '0 : col + 1'b1;
            end else begin
              case (in_data)
                ASCII_CR: col <= '0;
                ASCII_BS: begin
                  if (col != '0) begin
                    col     <= col - 1'b1;
                    vld_p1  <= 1'b1;
                    hpos_p1 <= col - 1'b1;
                    vpos_p1 <= row;
                    sym_p1  <= ASCII_SPACE;
                  end
                end
                ASCII_FF: begin
                  state <= ST_CLR_SCREEN;
                  col   <= '0;
                  row   <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        default: begin
          in_ready <= sw_done;
          if (sw_done) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign cursor_en     = (state == ST_IDLE);
  assign cursor_hpos   = col;
  assign cursor_vpos   = row;
  assign char_write_en = busy ? sw_active   : vld_p1;
  assign char_hpos     = busy ? sw_col      : hpos_p1;
  assign char_vpos     = busy ? sw_row      : vpos_p1;
  assign char_symbol   = busy ? ASCII_SPACE : sym_p1;

endmodule

// File: tb/tb_char_terminal_writer.sv
// Directed bench for char_terminal_writer: 8x3 instance for behaviour, 80x30 for defaults.
module tb_char_terminal_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, we, cen, busy;
  logic [2:0] hp, chp;
  logic [1:0] vp, cvp;
  logic [7:0] sym;

  logic       in_valid2 = 1'b0;
  logic [7:0] in_data2 = 8'h00;
  logic       in_ready2, we2, cen2, busy2;
  logic [6:0] hp2, chp2;
  logic [4:0] vp2, cvp2;
  logic [7:0] sym2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  char_terminal_writer #(.CHAR_HORZ_CNT(8), .CHAR_VERT_CNT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .char_hpos(hp), .char_vpos(vp), .char_write_en(we), .char_symbol(sym),
    .cursor_en(cen), .cursor_hpos(chp), .cursor_vpos(cvp), .busy(busy)
  );

  char_terminal_writer dut_full (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .char_hpos(hp2), .char_vpos(vp2), .char_write_en(we2), .char_symbol(sym2),
    .cursor_en(cen2), .cursor_hpos(chp2), .cursor_vpos(cvp2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cur(input string tag, input int h, input int v);
    chk({tag, ".cur_h"}, 32'(chp), h);
    chk({tag, ".cur_v"}, 32'(cvp), v);
  endtask

  task automatic chk_wr(input string tag, input int h, input int v, input int s);
    chk({tag, ".we"},  32'(we), 1);
    chk({tag, ".hp"},  32'(hp), h);
    chk({tag, ".vp"},  32'(vp), v);
    chk({tag, ".sym"}, 32'(sym), s);
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk("rst.we",   32'(we), 0);
    chk("rst.hp",   32'(hp), 0);
    chk("rst.vp",   32'(vp), 0);
    chk("rst.sym",  32'(sym), 'h20);
    chk("rst.cen",  32'(cen), 1);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.rdy",  32'(in_ready), 0);
    chk_cur("rst", 0, 0);
    rst = 1'b1;
    tick();
    chk("rel.rdy", 32'(in_ready), 1);

    // Single printable
    send(8'h41);
    chk_wr("A", 0, 0, 'h41);
    chk_cur("A", 1, 0);
    tick();
    chk("A.we_off", 32'(we), 0);

    // Eight back-to-back bytes wrap to next row without stalling
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h61;
      tick();
      chk_wr($sformatf("row%0d", i), i, 0, 'h61);
      chk($sformatf("row%0d.rdy", i), 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    chk_cur("row.end", 0, 1);

    // LF to non-wrapped row: no clear
    send(8'h0A);
    chk("lf1.we", 32'(we), 0);
    chk("lf1.busy", 32'(busy), 0);
    chk_cur("lf1", 0, 2);
    send(8'h78); send(8'h78); send(8'h78);
    chk_cur("x3", 3, 2);

    // LF from last row: wrap and clear row 0, source holds next byte meanwhile
    send(8'h0A);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    chk_cur("lfw", 3, 0);
    chk("lfw.rdy", 32'(in_ready), 0);
    chk("lfw.cen", 32'(cen), 0);
    for (int k = 0; k < 8; k++) begin
      chk_wr($sformatf("lclr%0d", k), k, 0, 'h20);
      chk($sformatf("lclr%0d.busy", k), 32'(busy), 1);
      tick();
    end
    chk("lclr.busy_end", 32'(busy), 0);
    chk("lclr.rdy_end", 32'(in_ready), 1);
    chk("lclr.we_end", 32'(we), 0);
    tick();
    in_valid = 1'b0;
    chk_wr("held", 3, 0, 'h5A);
    chk_cur("held", 4, 0);

    // Backspace at column 0 and mid-line
    send(8'h0D);
    chk("cr.we", 32'(we), 0);
    chk_cur("cr", 0, 0);
    send(8'h0A);
    send(8'h08);
    chk("bs0.we", 32'(we), 0);
    chk_cur("bs0", 0, 1);
    send(8'h62); send(8'h63);
    chk_cur("bc", 2, 1);
    send(8'h08);
    chk_wr("bs", 1, 1, 'h20);
    chk_cur("bs", 1, 1);

    // Form feed clears the whole screen row-major
    send(8'h0C);
    chk_cur("ff", 0, 0);
    for (int i = 0; i < 24; i++) begin
      chk_wr($sformatf("ff%0d", i), i % 8, i / 8, 'h20);
      chk($sformatf("ff%0d.busy", i), 32'(busy), 1);
      tick();
    end
    chk("ff.busy_end", 32'(busy), 0);
    chk("ff.rdy_end", 32'(in_ready), 1);
    chk("ff.we_end", 32'(we), 0);
    chk_cur("ff.end", 0, 0);

    // Reset in the middle of a screen clear
    send(8'h41);
    send(8'h0C);
    for (int i = 0; i < 10; i++) tick();
    chk_wr("ff10", 2, 1, 'h20);
    rst = 1'b0;
    #1;
    chk("arst.we",   32'(we), 0);
    chk("arst.hp",   32'(hp), 0);
    chk("arst.vp",   32'(vp), 0);
    chk("arst.sym",  32'(sym), 'h20);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.rdy",  32'(in_ready), 0);
    chk("arst.cen",  32'(cen), 1);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post%0d.we", i), 32'(we), 0);
    end
    send(8'h07);
    chk("bel.we", 32'(we), 0);
    chk("bel.rdy", 32'(in_ready), 1);
    chk_cur("bel", 0, 0);

    // Default 80x30 instance
    in_valid2 = 1'b1;
    in_data2  = 8'h41;
    tick();
    in_valid2 = 1'b0;
    chk("full.we",  32'(we2), 1);
    chk("full.hp",  32'(hp2), 0);
    chk("full.vp",  32'(vp2), 0);
    chk("full.sym", 32'(sym2), 'h41);
    chk("full.cur_h", 32'(chp2), 1);
    chk("full.cur_v", 32'(cvp2), 0);
    tick();
    chk("full.we_off", 32'(we2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
